cse_sub_pipe: RTL and testbench

CSE_SUB_PIPE -- requirements
Module: cse_sub_pipe

---
 rtl/rca_4.sv | 16 +
 rtl/cse_sub_pipe.sv | 124 ++++++++++++
 tb/tb_cse_sub_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rca_4.sv
// 4-bit ripple-carry adder: {co, s} = a + b + ci.
module rca_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
  assign s   = sum[3:0];
  assign co  = sum[4];

endmodule

// File: rtl/cse_sub_pipe.sv
// Two-stage 8-bit carry-select subtractor: {bout,d} = a - b - bin.
// Stage 1 adds a + ~b + ~bin with a low-nibble adder and two speculative
// high-nibble adders; stage 2 picks the high nibble by the low-nibble carry.
// Both stages use a valid/ready handshake with full-throughput backpressure.
module cse_sub_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] d,
  output logic       bout,
  output logic       z,
  output logic       out_valid,
  input  logic       out_ready
);

  // stage-1 adder outputs
  logic [3:0] lo_sum;
  logic       lo_co;
  logic [3:0] hi0_sum;
  logic       hi0_co;
  logic [3:0] hi1_sum;
  logic       hi1_co;

  // stage-1 registers
  logic       vld_p1;
  logic [3:0] d_lo_p1;
  logic       p_p1;
  logic [3:0] s0_p1;
  logic       c0_p1;
  logic [3:0] s1_p1;
  logic       c1_p1;

  // stage-2 select results
  logic [3:0] hi_sel;
  logic       co_sel;

  logic       s2_ready;
  logic       in_xfer;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~vld_p1 | s2_ready;
  assign in_xfer  = in_valid & in_ready;

  rca_4 u_rca_lo (
    .a  (a[3:0]),
    .b  (~b[3:0]),
    .ci (~bin),
    .s  (lo_sum),
    .co (lo_co)
  );

  rca_4 u_rca_hi0 (
    .a  (a[7:4]),
    .b  (~b[7:4]),
    .ci (1'b0),
    .s  (hi0_sum),
    .co (hi0_co)
  );

  rca_4 u_rca_hi1 (
    .a  (a[7:4]),
    .b  (~b[7:4]),
    .ci (1'b1),
    .s  (hi1_sum),
    .co (hi1_co)
  );

  // ---- stage 1 boundary ----

  // Stage-1 valid: refill or drain whenever stage 1 may move, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  // Stage-1 data: capture the low sum and both speculative high sums on accept.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      d_lo_p1 <= lo_sum;
      p_p1    <= lo_co;
      s0_p1   <= hi0_sum;
      c0_p1   <= hi0_co;
      s1_p1   <= hi1_sum;
      c1_p1   <= hi1_co;
    end
  end

  // Carry-select: low-nibble carry chooses the high-nibble sum and final carry.
  always_comb begin
    hi_sel = s0_p1;
    co_sel = c0_p1;
    if (p_p1) begin
      hi_sel = s1_p1;
      co_sel = c1_p1;
    end
  end

  // ---- stage 2 boundary ----

  // Output register: advance when downstream has room, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= 8'h00;
      bout      <= 1'b0;
      z         <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        d    <= {hi_sel, d_lo_p1};
        bout <= ~co_sel;
        z    <= ({hi_sel, d_lo_p1} == 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_cse_sub_pipe.sv
// Directed testbench for cse_sub_pipe with hand-computed expected values.
module tb_cse_sub_pipe;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       bout;
  logic       z;
  logic       out_valid;
  logic       out_ready;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  cse_sub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .bout      (bout),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ed, input logic eb, input logic ez);
    chk({tag, "_valid"}, {7'b0, out_valid}, 8'h01);
    chk({tag, "_d"}, d, ed);
    chk({tag, "_bout"}, {7'b0, bout}, {7'b0, eb});
    chk({tag, "_z"}, {7'b0, z}, {7'b0, ez});
  endtask

  initial begin
    rst_n     = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    bin       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // reset state, out_ready low
    #2;
    chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_d", d, 8'h00);
    chk("rst_bout", {7'b0, bout}, 8'h00);
    chk("rst_z", {7'b0, z}, 8'h00);
    step();
    step();
    chk("rst_in_ready2", {7'b0, in_ready}, 8'h01);
    rst_n = 1'b1;
    step();

    // single transaction latency: 50 - 30 = 20
    out_ready = 1'b1;
    drive(8'h50, 8'h30, 1'b0);
    step();
    in_valid = 1'b0;
    chk("lat_not_yet", {7'b0, out_valid}, 8'h00);
    step();
    chk_out("t50m30", 8'h20, 1'b0, 1'b0);
    step();
    chk("lat_drain", {7'b0, out_valid}, 8'h00);

    // back-to-back stream, one result per cycle
    drive(8'h30, 8'h50, 1'b0);
    step();
    drive(8'h00, 8'h00, 1'b1);
    step();
    chk_out("t30m50", 8'hE0, 1'b1, 1'b0);
    drive(8'h7F, 8'h7F, 1'b0);
    step();
    chk_out("t00m00b1", 8'hFF, 1'b1, 1'b0);
    drive(8'h10, 8'h01, 1'b0);
    step();
    chk_out("t7Fm7F", 8'h00, 1'b0, 1'b1);
    drive(8'h12, 8'h02, 1'b0);
    step();
    chk_out("t10m01", 8'h0F, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    chk_out("t12m02", 8'h10, 1'b0, 1'b0);
    step();
    chk("stream_drain", {7'b0, out_valid}, 8'h00);

    // backpressure: 05-1, 06-1, 07-1 with out_ready low
    out_ready = 1'b0;
    drive(8'h05, 8'h01, 1'b0);
    chk("bp_rdy_a", {7'b0, in_ready}, 8'h01);
    step();
    drive(8'h06, 8'h01, 1'b0);
    chk("bp_rdy_b", {7'b0, in_ready}, 8'h01);
    step();
    chk_out("bp_hold0", 8'h04, 1'b0, 1'b0);
    drive(8'h07, 8'h01, 1'b0);
    chk("bp_rdy_c", {7'b0, in_ready}, 8'h00);
    step();
    chk_out("bp_hold1", 8'h04, 1'b0, 1'b0);
    chk("bp_rdy_c2", {7'b0, in_ready}, 8'h00);
    step();
    chk_out("bp_hold2", 8'h04, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_open", {7'b0, in_ready}, 8'h01);
    step();
    in_valid = 1'b0;
    chk_out("bp_out05", 8'h05, 1'b0, 1'b0);
    step();
    chk_out("bp_out06", 8'h06, 1'b0, 1'b0);
    step();
    chk("bp_drain", {7'b0, out_valid}, 8'h00);

    // reset mid-operation with both stages full
    out_ready = 1'b0;
    drive(8'h09, 8'h01, 1'b0);
    step();
    drive(8'h0A, 8'h01, 1'b0);
    step();
    in_valid = 1'b0;
    chk("mid_full_rdy", {7'b0, in_ready}, 8'h00);
    chk_out("mid_full", 8'h08, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {7'b0, out_valid}, 8'h00);
    chk("mid_rst_d", d, 8'h00);
    chk("mid_rst_rdy", {7'b0, in_ready}, 8'h01);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_v0", {7'b0, out_valid}, 8'h00);
    step();
    chk("post_rst_v1", {7'b0, out_valid}, 8'h00);
    drive(8'h20, 8'h05, 1'b0);
    step();
    in_valid = 1'b0;
    chk("fresh_not_yet", {7'b0, out_valid}, 8'h00);
    step();
    chk_out("fresh", 8'h1B, 1'b0, 1'b0);
    step();
    chk("fresh_drain", {7'b0, out_valid}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
